// File: rtl/pet_mood_fsm.sv
// Pet mood tracker: evaluates six need stats once every TICK_DIV cycles into a registered mood/age/death state.
// Latency: a stat change is reflected in mood within TICK_DIV cycles; no backpressure, stats are sampled at the tick edge only.
// Build option: define MOOD_SLEEP_EN to add the SLEEPY mood driven by the energy stat.
module pet_mood_fsm #(
    parameter int TICK_DIV  = 1000,
    parameter int CRIT      = 12,
    parameter int SICK_HOLD = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  hunger,
    input  logic [3:0]  happiness,
    input  logic [3:0]  health,
    input  logic [3:0]  hygiene,
    input  logic [3:0]  energy,
    input  logic [3:0]  social,
    input  logic        revive,
    output logic [2:0]  mood,
    output logic        mood_chg,
    output logic        alert,
    output logic        dead,
    output logic [15:0] age
);

    typedef enum logic [2:0] {
        MOOD_OK     = 3'd0,
        MOOD_HUNGRY = 3'd1,
        MOOD_DIRTY  = 3'd2,
        MOOD_SAD    = 3'd3,
        MOOD_SICK   = 3'd4,
        MOOD_DEAD   = 3'd5,
        MOOD_SLEEPY = 3'd6
    } mood_e;

    localparam logic [15:0] TICK_MAX = 16'(TICK_DIV - 1);
    localparam logic [3:0]  CRIT_V   = 4'(CRIT);
    localparam logic [7:0]  HOLD_V   = 8'(SICK_HOLD);

    mood_e       mood_q, mood_d;
    logic [15:0] tick_cnt_q, tick_cnt_d;
    logic [15:0] age_q, age_d;
    logic [7:0]  sick_cnt_q, sick_cnt_d;
    logic        mood_chg_q, mood_chg_d;
    logic        alert_q, alert_d;
    logic        dead_q, dead_d;

    logic        tick;
    logic [7:0]  sick_inc;
    mood_e       eval_mood;

`ifndef MOOD_SLEEP_EN
    logic energy_unused;
    assign energy_unused = ^energy;
`endif

    // Non-sick priority; health is resolved separately because it also drives the death counter.
    always_comb begin
        eval_mood = MOOD_OK;
        if (hunger >= CRIT_V) begin
            eval_mood = MOOD_HUNGRY;
        end else if (hygiene >= CRIT_V) begin
            eval_mood = MOOD_DIRTY;
        end else if (happiness >= CRIT_V || social >= CRIT_V) begin
            eval_mood = MOOD_SAD;
        end
`ifdef MOOD_SLEEP_EN
        if (energy >= CRIT_V) begin
            eval_mood = MOOD_SLEEPY;
        end
`endif
    end

    always_comb begin
        tick       = (tick_cnt_q == TICK_MAX);
        sick_inc   = sick_cnt_q + 8'd1;
        tick_cnt_d = tick ? 16'd0 : tick_cnt_q + 16'd1;
        sick_cnt_d = sick_cnt_q;
        age_d      = age_q;
        mood_d     = mood_q;

        // Revive beats a coincident tick: the pet restarts with a fresh tick interval.
        if (mood_q == MOOD_DEAD && revive) begin
            mood_d     = MOOD_OK;
            sick_cnt_d = 8'd0;
            age_d      = 16'd0;
            tick_cnt_d = 16'd0;
        end else if (tick && mood_q != MOOD_DEAD) begin
            if (age_q != 16'hFFFF) begin
                age_d = age_q + 16'd1;
            end
            if (health >= CRIT_V) begin
                sick_cnt_d = sick_inc;
                mood_d     = (sick_inc == HOLD_V) ? MOOD_DEAD : MOOD_SICK;
            end else begin
                sick_cnt_d = 8'd0;
                mood_d     = eval_mood;
            end
        end

        mood_chg_d = (mood_d != mood_q);
        alert_d    = (mood_d != MOOD_OK) && (mood_d != MOOD_DEAD);
        dead_d     = (mood_d == MOOD_DEAD);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mood_q     <= MOOD_OK;
            tick_cnt_q <= 16'd0;
            age_q      <= 16'd0;
            sick_cnt_q <= 8'd0;
            mood_chg_q <= 1'b0;
            alert_q    <= 1'b0;
            dead_q     <= 1'b0;
        end else begin
            mood_q     <= mood_d;
            tick_cnt_q <= tick_cnt_d;
            age_q      <= age_d;
            sick_cnt_q <= sick_cnt_d;
            mood_chg_q <= mood_chg_d;
            alert_q    <= alert_d;
            dead_q     <= dead_d;
        end
    end

    assign mood     = mood_q;
    assign mood_chg = mood_chg_q;
    assign alert    = alert_q;
    assign dead     = dead_q;
    assign age      = age_q;

endmodule

// File: tb/tb_pet_mood_fsm.sv
// Bench for pet_mood_fsm: directed scenarios plus random stats/revive, checked against an epoch/tick reference model.
module tb_pet_mood_fsm;

    localparam int TICK_DIV  = 4;
    localparam int CRIT      = 12;
    localparam int SICK_HOLD = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  hunger, happiness, health, hygiene, energy, social;
    logic        revive;
    logic [2:0]  mood;
    logic        mood_chg, alert, dead;
    logic [15:0] age;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: edges since reset/revive, and the pet's observable condition.
    int m_ep, m_mood, m_age, m_sick, m_chg;

    pet_mood_fsm #(.TICK_DIV(TICK_DIV), .CRIT(CRIT), .SICK_HOLD(SICK_HOLD)) dut (
        .clk(clk), .reset(reset),
        .hunger(hunger), .happiness(happiness), .health(health),
        .hygiene(hygiene), .energy(energy), .social(social),
        .revive(revive),
        .mood(mood), .mood_chg(mood_chg), .alert(alert), .dead(dead), .age(age)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int wanted_mood();
        if (int'(health) >= CRIT) return 4;
`ifdef MOOD_SLEEP_EN
        if (int'(energy) >= CRIT) return 6;
`endif
        if (int'(hunger) >= CRIT) return 1;
        if (int'(hygiene) >= CRIT) return 2;
        if (int'(happiness) >= CRIT || int'(social) >= CRIT) return 3;
        return 0;
    endfunction

    task automatic model_reset();
        m_ep = 0; m_mood = 0; m_age = 0; m_sick = 0; m_chg = 0;
    endtask

    task automatic model_edge();
        int prev;
        prev = m_mood;
        if (m_mood == 5 && revive) begin
            m_mood = 0; m_age = 0; m_sick = 0; m_ep = 0;
        end else begin
            m_ep++;
            if (m_ep % TICK_DIV == 0 && m_mood != 5) begin
                if (int'(health) >= CRIT) begin
                    m_sick++;
                    m_mood = (m_sick == SICK_HOLD) ? 5 : 4;
                end else begin
                    m_sick = 0;
                    m_mood = wanted_mood();
                end
                if (m_age < 65535) m_age++;
            end
        end
        m_chg = (m_mood != prev) ? 1 : 0;
    endtask

    task automatic compare_all();
        check("mood", int'(mood), m_mood);
        check("mood_chg", int'(mood_chg), m_chg);
        check("alert", int'(alert), (m_mood != 0 && m_mood != 5) ? 1 : 0);
        check("dead", int'(dead), (m_mood == 5) ? 1 : 0);
        check("age", int'(age), m_age);
    endtask

    // Called at a negedge with inputs already applied; returns at the following negedge.
    task automatic step();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic run_to_tick();
        do step(); while (m_ep % TICK_DIV != 0);
    endtask

    task automatic zero_stats();
        hunger = 0; happiness = 0; health = 0; hygiene = 0; energy = 0; social = 0;
    endtask

    int a_death;

    initial begin
        reset = 1'b1; revive = 1'b0;
        zero_stats();
        model_reset();
        repeat (3) @(negedge clk);
        compare_all();
        reset = 1'b0;

        // Idle pet: ages one per tick, mood stays OK.
        repeat (12) step();
        check("t1_age", int'(age), 3);

        // Two needs raised mid-interval: hunger outranks hygiene.
        step();
        hunger = 12; hygiene = 13;
        run_to_tick();
        check("t2_mood", int'(mood), 1);
        check("t2_alert", int'(alert), 1);
        check("t2_chg", int'(mood_chg), 1);
        hunger = 3;
        run_to_tick();
        check("t2_dirty", int'(mood), 2);

        // Sustained sickness: dies on the third consecutive sick tick.
        zero_stats(); health = 15;
        run_to_tick();
        check("t3_sick1", int'(mood), 4);
        run_to_tick();
        check("t3_sick2", int'(mood), 4);
        run_to_tick();
        check("t3_dead_mood", int'(mood), 5);
        check("t3_dead", int'(dead), 1);
        a_death = m_age;
        run_to_tick();
        run_to_tick();
        check("t3_age_frozen", int'(age), a_death);
        check("t3_still_dead", int'(mood), 5);

        // Revive on the very edge that would be a tick.
        while ((m_ep + 1) % TICK_DIV != 0) step();
        revive = 1'b1;
        step();
        revive = 1'b0;
        check("t4_mood", int'(mood), 0);
        check("t4_age", int'(age), 0);
        check("t4_dead", int'(dead), 0);
        check("t4_chg", int'(mood_chg), 1);
        zero_stats();
        repeat (3) step();
        check("t4_no_early_tick", int'(age), 0);
        step();
        check("t4_tick_4_later", int'(age), 1);

        // Interrupted sickness restarts the death count.
        health = 12;
        run_to_tick();
        run_to_tick();
        health = 0;
        run_to_tick();
        health = 12;
        run_to_tick();
        run_to_tick();
        check("t5_alive", int'(dead), 0);
        check("t5_sick", int'(mood), 4);
        run_to_tick();
        check("t5_dead", int'(dead), 1);
        revive = 1'b1;
        step();
        revive = 1'b0;

        // Sleepiness vs hunger, then asynchronous reset mid-run.
        zero_stats(); energy = 12; hunger = 14;
        run_to_tick();
`ifdef MOOD_SLEEP_EN
        check("t6_sleepy", int'(mood), 6);
`else
        check("t6_hungry", int'(mood), 1);
`endif
        step();
        #2 reset = 1'b1;
        #1;
        check("t6_rst_mood", int'(mood), 0);
        check("t6_rst_chg", int'(mood_chg), 0);
        check("t6_rst_alert", int'(alert), 0);
        check("t6_rst_dead", int'(dead), 0);
        check("t6_rst_age", int'(age), 0);
        @(negedge clk);
        model_reset();
        reset = 1'b0;

        // Random soak: frequent sickness so deaths and revives both occur.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                hunger    = 4'($urandom_range(0, 15));
                happiness = 4'($urandom_range(0, 15));
                hygiene   = 4'($urandom_range(0, 15));
                energy    = 4'($urandom_range(0, 15));
                social    = 4'($urandom_range(0, 15));
                health    = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(12, 15))
                                                        : 4'($urandom_range(0, 11));
            end
            revive = ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0;
            step();
        end
        revive = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
